// File: rtl/dmem_responder.sv
// dmem_responder -- data-memory responder for a single-port core bus.
//
// Serves word RAM with combinational reads, a console TX byte FIFO, a
// one-shot TOHOST halt register, and sticky unmapped-access detection.
//
// Compile-time option:
//   DMEM_RESPONDER_CONSOLE_EN  when defined, builds the console FIFO and
//                              maps CON_DATA / CON_STATUS; otherwise both
//                              addresses are unmapped and con_* outputs are 0.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low
//   dmem_addr   byte address from core
//   dmem_wdata  store data (already lane-merged)
//   dmem_we     store strobe
//   dmem_rdata  load data, combinational from dmem_addr
//   con_valid   console byte available (FIFO not empty)
//   con_data    console byte at FIFO head
//   con_ready   sink accepts byte when con_valid && con_ready
//   halt        sticky, set the cycle after the first TOHOST store
//   tohost      value latched by the first TOHOST store
//   bus_err     sticky, set the cycle after any unmapped access
module dmem_responder #(
   parameter int XLEN       = 32,
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] dmem_addr,
   input  logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_we,
   output logic [XLEN-1:0] dmem_rdata,
   output logic            con_valid,
   output logic [7:0]      con_data,
   input  logic            con_ready,
   output logic            halt,
   output logic [XLEN-1:0] tohost,
   output logic            bus_err
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam logic [XLEN-1:0] TOHOST_A = XLEN'(32'h8000_0008);

   logic [XLEN-1:0] ram [RAM_WORDS];
   logic [AW-1:0]   ram_idx;
   logic [XLEN-1:0] ram_rd;
   logic            ram_hit;
   logic            tohost_hit;
   logic            con_data_hit;
   logic            con_status_hit;
   logic [XLEN-1:0] con_status;
   logic            mapped;
   logic            chk_rd;

   // The core always drives an address, so every cycle counts as a read
   // access for the purpose of unmapped-address detection.
   assign chk_rd = 1'b1;

   assign ram_idx    = dmem_addr[AW+1:2];
   assign ram_hit    = (dmem_addr[XLEN-1:AW+2] == '0);
   assign tohost_hit = (dmem_addr == TOHOST_A);
   assign mapped     = ram_hit | tohost_hit | con_data_hit | con_status_hit;

   // RAM: no reset, combinational read returns the pre-write word during a
   // same-cycle store.
   assign ram_rd = ram[ram_idx];

   always_ff @(posedge clk) begin
      if (dmem_we && ram_hit) begin
         ram[ram_idx] <= dmem_wdata;
      end
   end

`ifdef DMEM_RESPONDER_CONSOLE_EN
   localparam logic [XLEN-1:0] CON_DATA_A   = XLEN'(32'h8000_0000);
   localparam logic [XLEN-1:0] CON_STATUS_A = XLEN'(32'h8000_0004);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [7:0]  fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;
   logic [31:0]   count_w;
   logic [3:0]    count_sat;
   logic          overflow;
   logic          empty;
   logic          full;
   logic          push_req;
   logic          push_ok;
   logic          pop;

   assign con_data_hit   = (dmem_addr == CON_DATA_A);
   assign con_status_hit = (dmem_addr == CON_STATUS_A);

   assign empty    = (count == '0);
   assign full     = (count == (PW+1)'(FIFO_DEPTH));
   assign pop      = !empty && con_ready;
   assign push_req = dmem_we && con_data_hit;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is
   // still accepted then.
   assign push_ok  = push_req && (!full || pop);

   assign con_valid = !empty;
   assign con_data  = fifo_mem[rd_ptr];

   always_comb begin
      count_w   = 32'(count);
      count_sat = (count_w > 32'd15) ? 4'hF : count_w[3:0];
   end

   assign con_status = {{(XLEN-8){1'b0}}, count_sat, 1'b0, overflow, empty, full};

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= dmem_wdata[7:0];
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (dmem_we && con_status_hit) begin
            overflow <= 1'b0;
         end else if (push_req && !push_ok) begin
            overflow <= 1'b1;
         end
      end
   end
`else
   localparam int UNUSED_FIFO_DEPTH = FIFO_DEPTH;
   logic unused_con_ready;

   assign unused_con_ready = con_ready;
   assign con_data_hit     = 1'b0;
   assign con_status_hit   = 1'b0;
   assign con_status       = '0;
   assign con_valid        = 1'b0;
   assign con_data         = '0;
`endif

   always_comb begin
      dmem_rdata = '0;
      if (ram_hit) begin
         dmem_rdata = ram_rd;
      end else if (tohost_hit) begin
         dmem_rdata = tohost;
      end else if (con_status_hit) begin
         dmem_rdata = con_status;
      end
   end

   // halt doubles as the "already written" flag that blocks later TOHOST stores.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         halt    <= 1'b0;
         tohost  <= '0;
         bus_err <= 1'b0;
      end else begin
         if (dmem_we && tohost_hit && !halt) begin
            tohost <= dmem_wdata;
            halt   <= 1'b1;
         end
         if (!mapped && (dmem_we || chk_rd)) begin
            bus_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width of the core data-memory port.
REQ-002 SHALL have parameter RAM_WORDS, default 1024, RAM depth in XLEN-bit words (power of two).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, console TX FIFO depth in bytes (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port dmem_addr  input  XLEN  byte address from core.
REQ-007 SHALL have port dmem_wdata  input  XLEN  store data, already lane-merged by core.
REQ-008 SHALL have port dmem_we  input  1  store strobe, one word per cycle.
REQ-009 SHALL have port dmem_rdata  output  XLEN  load data, valid in the same cycle as dmem_addr.
REQ-010 SHALL have port con_valid  output  1  console byte available.
REQ-011 SHALL have port con_data  output  8  console byte (FIFO head).
REQ-012 SHALL have port con_ready  input  1  sink accepts byte when con_valid&&con_ready at clk edge.
REQ-013 SHALL have port halt  output  1  sticky; program wrote tohost.
REQ-014 SHALL have port tohost  output  XLEN  value latched by first tohost write.
REQ-015 SHALL have port bus_err  output  1  sticky; access to unmapped address.

Function
REQ-016 Address map SHALL be: RAM 0x0000_0000..RAM_WORDS*4-1; CON_DATA 0x8000_0000; CON_STATUS 0x8000_0004; TOHOST 0x8000_0008; all else unmapped.
REQ-017 RAM SHALL be word-indexed by dmem_addr[log2(RAM_WORDS)+1:2]; dmem_addr[1:0] ignored.
REQ-018 RAM reads SHALL be combinational (zero latency); writes SHALL commit at the clk edge where dmem_we=1.
REQ-019 Read-during-write to the same RAM word SHALL return the old word in that cycle and the new word from the next cycle.
REQ-020 Store to CON_DATA SHALL push dmem_wdata[7:0] into the FIFO; load from CON_DATA SHALL return 0.
REQ-021 CON_STATUS read SHALL return {zeros, count[7:4] (saturating to 15 if FIFO_DEPTH>15), overflow[2], empty[1], full[0]}; stores to CON_STATUS SHALL clear overflow.
REQ-022 Push while full with no same-cycle pop SHALL drop the byte and set sticky overflow.
REQ-023 Push and pop in the same cycle SHALL both take effect, count unchanged, including when full (push accepted) and when empty (push only, no pop).
REQ-024 con_valid SHALL equal !empty; con_data SHALL equal the head byte; a popped byte SHALL never reappear; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 First store to TOHOST SHALL latch dmem_wdata into tohost and set halt the next cycle; later TOHOST stores SHALL be ignored; TOHOST read SHALL return tohost.
REQ-026 Any load or store to an unmapped address SHALL return dmem_rdata=0, write nothing, and set bus_err from the next cycle.
REQ-027 Because the core always drives dmem_addr, unmapped-address detection SHALL occur only when dmem_we=1 or when chk_rd is high; chk_rd is tied 1 internally.

Reset
REQ-028 While reset=0: con_valid=0, FIFO empty, count=0, overflow=0, halt=0, tohost=0, bus_err=0, asynchronously.
REQ-029 RAM contents SHALL NOT be cleared by reset; reset mid-transfer SHALL discard all queued console bytes.
REQ-030 First state update after reset deassertion SHALL occur on the next clk rising edge.

Configuration
REQ-031 Macro DMEM_RESPONDER_CONSOLE_EN: when defined, the console FIFO and CON_DATA/CON_STATUS exist as above.
REQ-032 Without DMEM_RESPONDER_CONSOLE_EN: no FIFO storage, con_valid=0, con_data=0, con_ready ignored, CON_DATA/CON_STATUS treated as unmapped (REQ-026).

Verification
REQ-033 Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0012 -> dmem_rdata=0xDEADBEEF; same-cycle load during store to 0x10 with old 0x0 -> reads 0x0.
REQ-034 con_ready=0, push 9 bytes 0x41..0x49 (depth 8) -> CON_STATUS=0x0000_0085 (count 8, overflow, full); release con_ready -> 0x41..0x48 in order, then con_valid=0.
REQ-035 FIFO full, con_ready=1, push 0x5A same cycle -> count stays 8, no overflow, 0x5A emerges last.
REQ-036 Store 0x1 then 0x7 to TOHOST -> halt=1 one cycle after first store, tohost=0x0000_0001.
REQ-037 Load from 0x4000_0000 -> dmem_rdata=0, bus_err=1 next cycle; pulse reset=0 with 3 queued bytes -> con_valid=0, bus_err=0, RAM word 0x10 still 0xDEADBEEF.
